// File: rtl/pdn_rail_sequencer.sv
// pdn_rail_sequencer: ordered power-up/down of supply-switch enables with power-good gating and fault latch
module pdn_rail_sequencer #(
  parameter int NUM_RAILS      = 6,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pwr_req,
  input  logic [NUM_RAILS-1:0]         rail_pg,
  output logic [NUM_RAILS-1:0]         rail_en,
  output logic                         all_good,
  output logic                         busy,
  output logic                         fault,
  output logic [$clog2(NUM_RAILS)-1:0] fault_rail
);
  localparam int IW = $clog2(NUM_RAILS);
  typedef enum logic [2:0] {OFF, ENABLE, SETTLE, ON, DISABLE, FAULT} state_t;
  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n, frail_n, low;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [NUM_RAILS-1:0] en_n, lo, lo_eq, bad;
  logic                 fault_n, flt, settle_done;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= OFF;
      idx        <= '0;
      cnt        <= '0;
      rail_en    <= '0;
      fault      <= 1'b0;
      fault_rail <= '0;
      all_good   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      rail_en    <= en_n;
      fault      <= fault_n;
      fault_rail <= frail_n;
      all_good   <= state_n == ON;
      busy       <= state_n == ENABLE || state_n == SETTLE || state_n == DISABLE;
    end
  end
  always_comb begin
    lo  = '0;
    lo_eq = '0;
    low = '0;
    for (int i = 0; i < NUM_RAILS; i++) begin
      lo[i]    = i < int'(idx);
      lo_eq[i] = i <= int'(idx);
    end
    bad = state == ENABLE ? ~rail_pg & lo :
          state == SETTLE ? ~rail_pg & lo_eq :
          state == ON     ? ~rail_pg : '0;
    for (int i = NUM_RAILS - 1; i >= 0; i--)
      if (bad[i]) low = IW'(i);
    flt = |bad || (state == ENABLE && !rail_pg[idx] && cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    settle_done = cnt == CNT_W'(SETTLE_CYCLES - 1);
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    en_n    = rail_en;
    fault_n = fault;
    frail_n = fault_rail;
    if (flt) begin
      state_n = FAULT;
      en_n    = '0;
      fault_n = 1'b1;
      frail_n = |bad ? low : idx;
    end else if (!pwr_req && (state == ENABLE || state == SETTLE || state == ON)) begin
      state_n   = DISABLE;
      en_n[idx] = 1'b0;
      cnt_n     = '0;
    end else begin
      case (state)
        OFF: if (pwr_req) begin
          state_n = ENABLE;
          idx_n   = '0;
          cnt_n   = '0;
          en_n    = NUM_RAILS'(1);
        end
        ENABLE: begin
          state_n = rail_pg[idx] ? SETTLE : ENABLE;
          cnt_n   = rail_pg[idx] ? '0 : cnt + 1'b1;
        end
        SETTLE: if (!settle_done) cnt_n = cnt + 1'b1;
        else if (idx == IW'(NUM_RAILS - 1)) state_n = ON;
        else begin
          state_n     = ENABLE;
          idx_n       = idx + 1'b1;
          cnt_n       = '0;
          en_n[idx_n] = 1'b1;
        end
        DISABLE: if (!settle_done) cnt_n = cnt + 1'b1;
        else if (idx == '0) begin
          state_n = OFF;
          cnt_n   = '0;
        end else begin
          idx_n       = idx - 1'b1;
          cnt_n       = '0;
          en_n[idx_n] = 1'b0;
        end
        FAULT: if (!pwr_req) begin
          state_n = OFF;
          idx_n   = '0;
          cnt_n   = '0;
          fault_n = 1'b0;
          frail_n = '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// tb_pdn_rail_sequencer: table-driven and directed checks of rail sequencing, timeout, pg loss, abort and reset
module tb_pdn_rail_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, pwr_req;
  logic [5:0] rail_pg, rail_en, kill, pg_d1, pg_d2;
  logic       all_good, busy, fault;
  logic [2:0] fault_rail;
  int         checks = 0, failures = 0;
  typedef struct {
    logic       req;
    int         steps;
    logic [5:0] en;
    logic       ag, bsy, flt;
  } vec_t;
  vec_t tbl[14];
  pdn_rail_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pwr_req(pwr_req), .rail_pg(rail_pg),
    .rail_en(rail_en), .all_good(all_good), .busy(busy), .fault(fault), .fault_rail(fault_rail)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pg_d1 <= rail_en;
    pg_d2 <= pg_d1;
  end
  assign rail_pg = pg_d2 & ~kill;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input int en, input int ag, input int bsy, input int flt, input int fr);
    chk({nm, ".rail_en"}, int'(rail_en), en);
    chk({nm, ".all_good"}, int'(all_good), ag);
    chk({nm, ".busy"}, int'(busy), bsy);
    chk({nm, ".fault"}, int'(fault), flt);
    chk({nm, ".fault_rail"}, int'(fault_rail), fr);
  endtask
  initial begin
    tbl[0]  = '{1'b1,  1, 6'h01, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 18, 6'h01, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1,  1, 6'h03, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 76, 6'h3f, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 18, 6'h3f, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b1,  1, 6'h3f, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1,  5, 6'h3f, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0,  1, 6'h1f, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 15, 6'h1f, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0,  1, 6'h0f, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 63, 6'h01, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0,  1, 6'h00, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 15, 6'h00, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0,  1, 6'h00, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0;
    pwr_req = 1'b0;
    kill = '0;
    step(2);
    chk_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(2);
    for (int i = 0; i < 14; i++) begin
      pwr_req = tbl[i].req;
      step(tbl[i].steps);
      chk_all($sformatf("vec%0d", i), int'(tbl[i].en), int'(tbl[i].ag), int'(tbl[i].bsy), int'(tbl[i].flt), 0);
    end
    kill = 6'b001000;
    pwr_req = 1'b1;
    step(313);
    chk_all("timeout_pre", 6'h0f, 0, 1, 0, 0);
    step(1);
    chk_all("timeout", 0, 0, 0, 1, 3);
    step(20);
    chk_all("timeout_hold", 0, 0, 0, 1, 3);
    pwr_req = 1'b0;
    step(1);
    chk_all("timeout_clear", 0, 0, 0, 0, 0);
    kill = '0;
    step(4);
    pwr_req = 1'b1;
    step(115);
    chk_all("pgloss_on", 6'h3f, 1, 0, 0, 0);
    kill = 6'b010100;
    step(1);
    kill = '0;
    chk_all("pgloss", 0, 0, 0, 1, 2);
    pwr_req = 1'b0;
    step(1);
    chk_all("pgloss_clear", 0, 0, 0, 0, 0);
    step(4);
    pwr_req = 1'b1;
    step(46);
    chk_all("abort_settle2", 6'h07, 0, 1, 0, 0);
    pwr_req = 1'b0;
    step(1);
    chk_all("abort_drop2", 6'h03, 0, 1, 0, 0);
    step(15);
    chk_all("abort_hold1", 6'h03, 0, 1, 0, 0);
    step(1);
    chk_all("abort_drop1", 6'h01, 0, 1, 0, 0);
    pwr_req = 1'b1;
    step(8);
    chk_all("abort_rereq", 6'h01, 0, 1, 0, 0);
    step(8);
    chk_all("abort_drop0", 0, 0, 1, 0, 0);
    step(15);
    chk_all("abort_tail", 0, 0, 1, 0, 0);
    step(1);
    chk_all("abort_off", 0, 0, 0, 0, 0);
    step(1);
    chk_all("abort_restart", 6'h01, 0, 1, 0, 0);
    step(85);
    chk_all("rst_settle4", 6'h1f, 0, 1, 0, 0);
    rst_n = 1'b0;
    step(1);
    chk_all("rst_mid", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1);
    chk_all("rst_restart", 6'h01, 0, 1, 0, 0);
    pwr_req = 1'b0;
    step(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
